// File: rtl/cp0_timer_irq.sv
// Coprocessor-0 subset: SR/Cause/EPC/PRId with interrupt and exception entry.
// Define CP0_TIMER_IRQ_TIMER_EN to add the Count/Compare timer and its TI interrupt.
module cp0_timer_irq #(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] PRID      = 32'h0000_0007
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [4:0]           CP0Add,
  input  logic [31:0]          CP0In,
  output logic [31:0]          CP0Out,
  input  logic [31:0]          VPC,
  input  logic                 BDIn,
  input  logic [4:0]           ExcCodeIn,
  input  logic [NUM_HWINT-1:0] HWInt,
  input  logic                 EXLClr,
  output logic [31:0]          EPCOut,
  output logic                 Req
);

  localparam int IPHI = 9 + NUM_HWINT;

  logic [NUM_HWINT-1:0] im_reg;
  logic [NUM_HWINT-1:0] ip_reg;
  logic                 exl_reg;
  logic                 ie_reg;
  logic                 bd_reg;
  logic [4:0]           exccode_reg;
  logic [31:0]          epc_reg;

  logic [NUM_HWINT-1:0] ip_eff;
  logic                 ti_flag;
  logic                 int_req;
  logic                 exc_req;
  logic                 wr_en;
  logic [31:0]          epc_target;
  logic [31:0]          sr_val;
  logic [31:0]          cause_val;

`ifdef CP0_TIMER_IRQ_TIMER_EN
  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic        ti_reg;

  assign ti_flag = ti_reg;

  // A Compare write clears TI even when the old values happen to match.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg   <= 32'd0;
      compare_reg <= 32'd0;
      ti_reg      <= 1'b0;
    end else begin
      if (wr_en && CP0Add == 5'd9)
        count_reg <= CP0In;
      else
        count_reg <= count_reg + 32'd1;

      if (wr_en && CP0Add == 5'd11) begin
        compare_reg <= CP0In;
        ti_reg      <= 1'b0;
      end else if (count_reg == compare_reg && compare_reg != 32'd0) begin
        ti_reg <= 1'b1;
      end
    end
  end
`else
  assign ti_flag = 1'b0;
`endif

  // TI shares the highest implemented IP line.
  for (genvar gi = 0; gi < NUM_HWINT; gi++) begin : g_ip
    if (gi == NUM_HWINT - 1) begin : g_top
      assign ip_eff[gi] = ip_reg[gi] | ti_flag;
    end else begin : g_low
      assign ip_eff[gi] = ip_reg[gi];
    end
  end

  assign int_req    = ie_reg & ~exl_reg & (|(ip_eff & im_reg));
  assign exc_req    = ~exl_reg & (ExcCodeIn != 5'd0);
  assign Req        = int_req | exc_req;
  assign wr_en      = en & ~Req;
  assign epc_target = (BDIn ? (VPC - 32'd4) : VPC) & ~32'd3;
  assign EPCOut     = (en && CP0Add == 5'd14) ? CP0In : epc_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      im_reg      <= '0;
      ip_reg      <= '0;
      exl_reg     <= 1'b0;
      ie_reg      <= 1'b0;
      bd_reg      <= 1'b0;
      exccode_reg <= 5'd0;
      epc_reg     <= 32'd0;
    end else begin
      ip_reg <= HWInt;
      if (wr_en && CP0Add == 5'd12) begin
        im_reg  <= CP0In[IPHI:10];
        exl_reg <= CP0In[1];
        ie_reg  <= CP0In[0];
      end
      if (wr_en && CP0Add == 5'd14)
        epc_reg <= CP0In;
      if (EXLClr)
        exl_reg <= 1'b0;
      // Exception entry wins over eret and software writes in the same cycle.
      if (Req) begin
        exl_reg     <= 1'b1;
        bd_reg      <= BDIn;
        epc_reg     <= epc_target;
        exccode_reg <= int_req ? 5'd0 : ExcCodeIn;
      end
    end
  end

  always_comb begin
    sr_val           = 32'd0;
    sr_val[IPHI:10]  = im_reg;
    sr_val[1]        = exl_reg;
    sr_val[0]        = ie_reg;
    cause_val           = 32'd0;
    cause_val[31]       = bd_reg;
    cause_val[IPHI:10]  = ip_eff;
    cause_val[6:2]      = exccode_reg;
  end

  always_comb begin
    CP0Out = 32'd0;
    case (CP0Add)
      5'd12:   CP0Out = sr_val;
      5'd13:   CP0Out = cause_val;
      5'd14:   CP0Out = epc_reg;
      5'd15:   CP0Out = PRID;
`ifdef CP0_TIMER_IRQ_TIMER_EN
      5'd9:    CP0Out = count_reg;
      5'd11:   CP0Out = compare_reg;
`endif
      default: CP0Out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_timer_irq.sv
// Directed bench for cp0_timer_irq; timer scenarios run when CP0_TIMER_IRQ_TIMER_EN is defined.
module tb_cp0_timer_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;

  int total = 0;
  int bad   = 0;

  cp0_timer_irq #(.NUM_HWINT(6), .PRID(32'h0000_0007)) dut (
    .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In),
    .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
    .HWInt(HWInt), .EXLClr(EXLClr), .EPCOut(EPCOut), .Req(Req)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; CP0Add = 5'd0; CP0In = 32'd0; VPC = 32'd0;
    BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    // A concurrent SR write must lose against reset.
    en = 1'b1; CP0Add = 5'd12; CP0In = 32'hFFFF_FFFF; HWInt = 6'h3F;
    tick();
    tick();
    reset = 1'b1;
    idle();
    #1;
    for (int a = 12; a <= 14; a++) begin
      CP0Add = 5'(a); #1;
      total++;
      if (CP0Out !== 32'd0) begin bad++; $display("FAIL reset_reg%0d: got %h want %h", a, CP0Out, 32'd0); end
    end
    CP0Add = 5'd15; #1;
    total++;
    if (CP0Out !== 32'h0000_0007) begin bad++; $display("FAIL reset_prid: got %h want %h", CP0Out, 32'h7); end
    total++;
    if (Req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", Req); end
    total++;
    if (EPCOut !== 32'd0) begin bad++; $display("FAIL reset_epcout: got %h want 0", EPCOut); end
    $display("test_reset done");
  endtask

  task automatic test_interrupt();
    en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_FC01;
    tick();
    idle();
    CP0Add = 5'd12; #1;
    total++;
    if (CP0Out !== 32'h0000_FC01) begin bad++; $display("FAIL int_sr_write: got %h want %h", CP0Out, 32'hFC01); end
    HWInt = 6'b000100; VPC = 32'h0000_2008; #1;
    total++;
    if (Req !== 1'b0) begin bad++; $display("FAIL int_req_lag: got %b want 0", Req); end
    tick();
    total++;
    if (Req !== 1'b1) begin bad++; $display("FAIL int_req: got %b want 1", Req); end
    tick();
    CP0Add = 5'd13; #1;
    total++;
    if (CP0Out !== 32'h0000_1000) begin bad++; $display("FAIL int_cause: got %h want %h", CP0Out, 32'h1000); end
    CP0Add = 5'd12; #1;
    total++;
    if (CP0Out !== 32'h0000_FC03) begin bad++; $display("FAIL int_sr_exl: got %h want %h", CP0Out, 32'hFC03); end
    CP0Add = 5'd14; #1;
    total++;
    if (CP0Out !== 32'h0000_2008) begin bad++; $display("FAIL int_epc: got %h want %h", CP0Out, 32'h2008); end
    total++;
    if (EPCOut !== 32'h0000_2008) begin bad++; $display("FAIL int_epcout: got %h want %h", EPCOut, 32'h2008); end
    // EXL is set while the line is still pending and enabled: no new request.
    total++;
    if (Req !== 1'b0) begin bad++; $display("FAIL int_exl_mask: got %b want 0", Req); end
    HWInt = 6'd0; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0; CP0Add = 5'd12; #1;
    total++;
    if (CP0Out !== 32'h0000_FC01) begin bad++; $display("FAIL int_eret: got %h want %h", CP0Out, 32'hFC01); end
    $display("test_interrupt done");
  endtask

  task automatic test_exc_delay_slot();
    ExcCodeIn = 5'd10; BDIn = 1'b1; VPC = 32'h0000_3010;
    en = 1'b1; CP0Add = 5'd14; CP0In = 32'hDEAD_0000;
    #1;
    total++;
    if (Req !== 1'b1) begin bad++; $display("FAIL exc_req: got %b want 1", Req); end
    tick();
    idle();
    ExcCodeIn = 5'd10; CP0Add = 5'd14; #1;
    total++;
    if (CP0Out !== 32'h0000_300C) begin bad++; $display("FAIL exc_epc: got %h want %h", CP0Out, 32'h300C); end
    CP0Add = 5'd13; #1;
    total++;
    if (CP0Out !== 32'h8000_0028) begin bad++; $display("FAIL exc_cause: got %h want %h", CP0Out, 32'h8000_0028); end
    total++;
    if (Req !== 1'b0) begin bad++; $display("FAIL exc_exl_mask: got %b want 0", Req); end
    ExcCodeIn = 5'd0; EXLClr = 1'b1;
    tick();
    idle();
    $display("test_exc_delay_slot done");
  endtask

  task automatic test_int_plus_exc();
    HWInt = 6'b000001;
    tick();
    ExcCodeIn = 5'd4; VPC = 32'h0000_5004; #1;
    total++;
    if (Req !== 1'b1) begin bad++; $display("FAIL ipe_req: got %b want 1", Req); end
    tick();
    ExcCodeIn = 5'd0; CP0Add = 5'd13; #1;
    total++;
    if (CP0Out !== 32'h0000_0400) begin bad++; $display("FAIL ipe_cause: got %h want %h", CP0Out, 32'h400); end
    CP0Add = 5'd14; #1;
    total++;
    if (CP0Out !== 32'h0000_5004) begin bad++; $display("FAIL ipe_epc: got %h want %h", CP0Out, 32'h5004); end
    HWInt = 6'd0; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0; CP0Add = 5'd12; #1;
    total++;
    if (CP0Out !== 32'h0000_FC01) begin bad++; $display("FAIL ipe_exlclr: got %h want %h", CP0Out, 32'hFC01); end
    $display("test_int_plus_exc done");
  endtask

  task automatic test_forward();
    en = 1'b1; CP0Add = 5'd14; CP0In = 32'h0000_4000; #1;
    total++;
    if (EPCOut !== 32'h0000_4000) begin bad++; $display("FAIL fwd_epcout: got %h want %h", EPCOut, 32'h4000); end
    total++;
    if (CP0Out !== 32'h0000_5004) begin bad++; $display("FAIL fwd_old_read: got %h want %h", CP0Out, 32'h5004); end
    tick();
    en = 1'b0; #1;
    total++;
    if (CP0Out !== 32'h0000_4000) begin bad++; $display("FAIL fwd_new_read: got %h want %h", CP0Out, 32'h4000); end
    en = 1'b1; CP0Add = 5'd13; CP0In = 32'hFFFF_FFFF;
    tick();
    en = 1'b0; #1;
    total++;
    if (CP0Out !== 32'd0) begin bad++; $display("FAIL cause_ro: got %h want 0", CP0Out); end
    CP0Add = 5'd3; #1;
    total++;
    if (CP0Out !== 32'd0) begin bad++; $display("FAIL unmapped: got %h want 0", CP0Out); end
    idle();
    $display("test_forward done");
  endtask

`ifdef CP0_TIMER_IRQ_TIMER_EN
  task automatic test_timer();
    en = 1'b1; CP0Add = 5'd11; CP0In = 32'd5;
    tick();
    CP0Add = 5'd9; CP0In = 32'd0;
    tick();
    en = 1'b0; #1;
    total++;
    if (CP0Out !== 32'd0) begin bad++; $display("FAIL tmr_count_load: got %h want 0", CP0Out); end
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (CP0Out !== 32'd5) begin bad++; $display("FAIL tmr_count5: got %h want 5", CP0Out); end
    total++;
    if (Req !== 1'b0) begin bad++; $display("FAIL tmr_req_early: got %b want 0", Req); end
    tick();
    total++;
    if (Req !== 1'b1) begin bad++; $display("FAIL tmr_req: got %b want 1", Req); end
    CP0Add = 5'd13; #1;
    total++;
    if (CP0Out !== 32'h0000_8000) begin bad++; $display("FAIL tmr_ti: got %h want %h", CP0Out, 32'h8000); end
    tick();
    en = 1'b1; CP0Add = 5'd11; CP0In = 32'h0000_0100;
    tick();
    en = 1'b0; CP0Add = 5'd13; #1;
    total++;
    if (CP0Out !== 32'd0) begin bad++; $display("FAIL tmr_ti_clear: got %h want 0", CP0Out); end
    en = 1'b1; CP0Add = 5'd9; CP0In = 32'hFFFF_FFFF;
    tick();
    en = 1'b0; #1;
    total++;
    if (CP0Out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL tmr_count_max: got %h want ffffffff", CP0Out); end
    tick();
    total++;
    if (CP0Out !== 32'd0) begin bad++; $display("FAIL tmr_wrap: got %h want 0", CP0Out); end
    EXLClr = 1'b1;
    tick();
    idle();
    $display("test_timer done");
  endtask
`else
  task automatic test_timer();
    en = 1'b1; CP0Add = 5'd9; CP0In = 32'h0000_0123;
    tick();
    CP0Add = 5'd11;
    tick();
    en = 1'b0; CP0Add = 5'd9; #1;
    total++;
    if (CP0Out !== 32'd0) begin bad++; $display("FAIL notmr_count: got %h want 0", CP0Out); end
    CP0Add = 5'd11; #1;
    total++;
    if (CP0Out !== 32'd0) begin bad++; $display("FAIL notmr_compare: got %h want 0", CP0Out); end
    total++;
    if (Req !== 1'b0) begin bad++; $display("FAIL notmr_req: got %b want 0", Req); end
    idle();
    $display("test_timer done");
  endtask
`endif

  initial begin
    test_reset();
    test_interrupt();
    test_exc_delay_slot();
    test_int_plus_exc();
    test_forward();
    test_timer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
